// File: rtl/rx_stm_frmctl.sv
// STM-1 receive frame alignment: A1/A2 pattern check, HUNT/PRESYNC/SYNC
// tracking with OOF/LOF, and row/column sequencing of the byte stream.
module rx_stm_frmctl #(
  parameter logic [7:0]  A1_VAL    = 8'hF6,
  parameter logic [7:0]  A2_VAL    = 8'h28,
  parameter int unsigned PRESYNC_N = 2,
  parameter int unsigned OOF_N     = 4,
  parameter int unsigned LOF_SET   = 24,
  parameter int unsigned LOF_CLR   = 24
) (
  input  logic       clk19,
  input  logic       rst19_n,
  input  logic [7:0] pdi,
  input  logic       pvld,
  input  logic       sofi,
  output logic [7:0] pdo,
  output logic       pvldo,
  output logic       sofo,
  output logic [3:0] row,
  output logic [8:0] col,
  output logic       toh_en,
  output logic       spe_en,
  output logic       oof,
  output logic       lof,
  output logic [1:0] state
);

  localparam int unsigned GW = (PRESYNC_N > 1) ? $clog2(PRESYNC_N) : 1;
  localparam int unsigned BW = (OOF_N > 1) ? $clog2(OOF_N) : 1;
  localparam int unsigned SW = (LOF_SET > 1) ? $clog2(LOF_SET) : 1;
  localparam int unsigned CW = (LOF_CLR > 1) ? $clog2(LOF_CLR) : 1;

  localparam logic [GW-1:0] GOOD_LAST = GW'(PRESYNC_N - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(OOF_N - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(LOF_SET - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(LOF_CLR - 1);
  localparam logic [8:0]    LAST_COL  = 9'd269;
  localparam logic [3:0]    LAST_ROW  = 4'd8;
  localparam logic [11:0]   LAST_BYTE = 12'd2429;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } fsm_t;

  fsm_t          st, st_n;
  logic [3:0]    cur_row, row_n, adv_row;
  logic [8:0]    cur_col, col_n, adv_col;
  logic          mm, mm_n;
  logic [GW-1:0] good_cnt, good_n;
  logic [BW-1:0] bad_cnt, bad_n;
  logic          oof_r, oof_n;
  logic          lof_r;
  logic [11:0]   byte_cnt;
  logic [SW-1:0] set_cnt;
  logic [CW-1:0] clr_cnt;

  logic [7:0]    exp_byte;
  logic          byte_ok, in_win, at_verdict, frame_good, tick;

  always_comb begin
    exp_byte   = (cur_col < 9'd3) ? A1_VAL : A2_VAL;
    byte_ok    = (pdi == exp_byte);
    in_win     = (cur_row == 4'd0) && (cur_col <= 9'd5);
    at_verdict = (cur_row == 4'd0) && (cur_col == 9'd5);
    frame_good = byte_ok && !mm;
    tick       = pvld && (byte_cnt == LAST_BYTE);
    adv_col    = (cur_col == LAST_COL) ? '0 : cur_col + 9'd1;
    if (cur_col == LAST_COL)
      adv_row = (cur_row == LAST_ROW) ? '0 : cur_row + 4'd1;
    else
      adv_row = cur_row;

    st_n   = st;
    oof_n  = oof_r;
    row_n  = cur_row;
    col_n  = cur_col;
    mm_n   = mm;
    good_n = good_cnt;
    bad_n  = bad_cnt;

    if (pvld) begin
      case (st)
        HUNT: begin
          // A candidate is opened only by an A1 byte carrying sofi; an
          // aborting byte never reopens one, even if it carries sofi.
          if (cur_col == '0) begin
            if (sofi && byte_ok)
              col_n = 9'd1;
          end else if (!byte_ok) begin
            col_n = '0;
          end else if (cur_col == 9'd5) begin
            st_n   = PRESYNC;
            col_n  = 9'd6;
            good_n = GW'(1);
          end else begin
            col_n = cur_col + 9'd1;
          end
        end
        default: begin
          row_n = adv_row;
          col_n = adv_col;
          if (in_win)
            mm_n = (cur_col == '0) ? !byte_ok : (mm || !byte_ok);
          if (at_verdict) begin
            if (st == PRESYNC) begin
              if (!frame_good) begin
                st_n  = HUNT;
                row_n = '0;
                col_n = '0;
              end else if (good_cnt == GOOD_LAST) begin
                st_n  = SYNC;
                oof_n = 1'b0;
                bad_n = '0;
              end else begin
                good_n = good_cnt + GW'(1);
              end
            end else begin
              if (frame_good) begin
                bad_n = '0;
              end else if (bad_cnt == BAD_LAST) begin
                st_n  = HUNT;
                oof_n = 1'b1;
                row_n = '0;
                col_n = '0;
                bad_n = '0;
              end else begin
                bad_n = bad_cnt + BW'(1);
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk19) begin
    if (!rst19_n) begin
      st       <= HUNT;
      cur_row  <= '0;
      cur_col  <= '0;
      mm       <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      oof_r    <= 1'b1;
      lof_r    <= 1'b0;
      byte_cnt <= '0;
      set_cnt  <= '0;
      clr_cnt  <= '0;
      pdo      <= '0;
      pvldo    <= 1'b0;
      sofo     <= 1'b0;
      row      <= '0;
      col      <= '0;
      toh_en   <= 1'b0;
      spe_en   <= 1'b0;
      oof      <= 1'b1;
      lof      <= 1'b0;
      state    <= 2'd0;
    end else begin
      st       <= st_n;
      cur_row  <= row_n;
      cur_col  <= col_n;
      mm       <= mm_n;
      good_cnt <= good_n;
      bad_cnt  <= bad_n;
      oof_r    <= oof_n;

      pdo    <= pdi;
      pvldo  <= pvld;
      sofo   <= pvld && (st == SYNC) && (cur_row == '0) && (cur_col == '0);
      toh_en <= pvld && (st != HUNT) && (cur_col < 9'd9);
      spe_en <= pvld && (st != HUNT) && (cur_col >= 9'd9);
      if (pvld) begin
        row      <= cur_row;
        col      <= cur_col;
        byte_cnt <= tick ? '0 : byte_cnt + 12'd1;
      end

      // Status ports trail the byte that caused a verdict by one cycle.
      state <= st;
      oof   <= oof_r;
      lof   <= lof_r;

      // Ticks are judged against the post-update oof/state of the same byte.
      if (!oof_n) begin
        set_cnt <= '0;
      end else if (tick && !lof_r) begin
        if (set_cnt == SET_LAST)
          lof_r <= 1'b1;
        else
          set_cnt <= set_cnt + SW'(1);
      end

      if (!lof_r || (st_n != SYNC)) begin
        clr_cnt <= '0;
      end else if (tick) begin
        if (clr_cnt == CLR_LAST) begin
          lof_r   <= 1'b0;
          clr_cnt <= '0;
        end else begin
          clr_cnt <= clr_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_stm_frmctl.sv
// Bench for rx_stm_frmctl: hand table for reset/HUNT corners, directed
// lock/OOF/LOF/gap/reset sequences and a randomized run against a frame model.
module tb_rx_stm_frmctl;

  localparam logic [7:0] A1    = 8'hF6;
  localparam logic [7:0] A2    = 8'h28;
  localparam int         PRE_N = 2;
  localparam int         OOF_K = 4;
  localparam int         LSET  = 4;
  localparam int         LCLR  = 3;
  localparam int         FRAME = 2430;

  logic       clk19 = 1'b0;
  logic       rst19_n;
  logic [7:0] pdi;
  logic       pvld, sofi;
  logic [7:0] pdo;
  logic       pvldo, sofo, toh_en, spe_en, oof, lof;
  logic [3:0] row;
  logic [8:0] col;
  logic [1:0] state;

  always #5 clk19 = ~clk19;

  rx_stm_frmctl #(
    .A1_VAL(A1), .A2_VAL(A2), .PRESYNC_N(PRE_N), .OOF_N(OOF_K),
    .LOF_SET(LSET), .LOF_CLR(LCLR)
  ) dut (
    .clk19(clk19), .rst19_n(rst19_n), .pdi(pdi), .pvld(pvld), .sofi(sofi),
    .pdo(pdo), .pvldo(pvldo), .sofo(sofo), .row(row), .col(col),
    .toh_en(toh_en), .spe_en(spe_en), .oof(oof), .lof(lof), .state(state)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position as a linear byte index, window verdict
  // as a whole-array comparison against the A1A1A1A2A2A2 pattern.
  int m_st, m_pos, m_good, m_bad, m_oof, m_lof, m_bytes, m_set, m_clr;
  logic [7:0] m_win [6];
  int e_pdo, e_pvldo, e_sofo, e_row, e_col, e_toh, e_spe, e_state, e_oof, e_lof;

  function automatic logic [7:0] pat(input int i);
    return (i < 3) ? A1 : A2;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_pos = 0; m_good = 0; m_bad = 0; m_oof = 1; m_lof = 0;
    m_bytes = 0; m_set = 0; m_clr = 0;
    for (int i = 0; i < 6; i++) m_win[i] = '0;
    e_pdo = 0; e_pvldo = 0; e_sofo = 0; e_row = 0; e_col = 0;
    e_toh = 0; e_spe = 0; e_state = 0; e_oof = 1; e_lof = 0;
  endfunction

  function automatic void model_step(input logic r, input logic [7:0] d,
                                     input logic v, input logic s);
    bit tick, ok;
    int nxt;
    if (!r) begin
      model_reset();
      return;
    end
    e_state = m_st; e_oof = m_oof; e_lof = m_lof;
    e_pdo = d; e_pvldo = v; e_sofo = 0; e_toh = 0; e_spe = 0;
    if (!v) return;
    e_row  = m_pos / 270;
    e_col  = m_pos % 270;
    e_sofo = (m_st == 2 && m_pos == 0);
    e_toh  = (m_st != 0 && e_col < 9);
    e_spe  = (m_st != 0 && e_col >= 9);
    tick    = (m_bytes == FRAME - 1);
    m_bytes = (m_bytes + 1) % FRAME;
    if (m_st == 0) begin
      if (m_pos == 0) begin
        if (s && d == pat(0)) m_pos = 1;
      end else if (d != pat(m_pos)) begin
        m_pos = 0;
      end else if (m_pos == 5) begin
        m_st = 1; m_pos = 6; m_good = 1;
      end else begin
        m_pos++;
      end
    end else begin
      if (m_pos < 6) m_win[m_pos] = d;
      nxt = (m_pos + 1) % FRAME;
      if (m_pos == 5) begin
        ok = 1;
        for (int i = 0; i < 6; i++) if (m_win[i] != pat(i)) ok = 0;
        if (m_st == 1) begin
          if (!ok) begin
            m_st = 0; nxt = 0;
          end else begin
            m_good++;
            if (m_good == PRE_N) begin m_st = 2; m_oof = 0; m_bad = 0; end
          end
        end else if (ok) begin
          m_bad = 0;
        end else begin
          m_bad++;
          if (m_bad == OOF_K) begin m_st = 0; m_oof = 1; nxt = 0; m_bad = 0; end
        end
      end
      m_pos = nxt;
    end
    if (m_oof != 0) begin
      if (tick && m_lof == 0) begin
        m_set++;
        if (m_set == LSET) m_lof = 1;
      end
    end else begin
      m_set = 0;
    end
    if (m_lof != 0 && m_st == 2) begin
      if (tick) begin
        m_clr++;
        if (m_clr == LCLR) begin m_lof = 0; m_clr = 0; end
      end
    end else begin
      m_clr = 0;
    end
  endfunction

  int vb_cnt = 0;
  int last_sofo = -1;
  int sofo_cnt = 0;
  int g_pos = 0;

  task automatic cycle(input logic r, input logic [7:0] d, input logic v,
                       input logic s, input bit chk);
    rst19_n = r; pdi = d; pvld = v; sofi = s;
    @(posedge clk19);
    model_step(r, d, v, s);
    #1;
    if (chk) begin
      check("pdo", pdo, e_pdo);
      check("pvldo", pvldo, e_pvldo);
      check("sofo", sofo, e_sofo);
      check("row", row, e_row);
      check("col", col, e_col);
      check("toh_en", toh_en, e_toh);
      check("spe_en", spe_en, e_spe);
      check("state", state, e_state);
      check("oof", oof, e_oof);
      check("lof", lof, e_lof);
    end
    if (e_pvldo != 0) vb_cnt++;
    if (e_state == 0) last_sofo = -1;
    if (sofo) begin
      sofo_cnt++;
      if (last_sofo >= 0) check("sofo_gap", vb_cnt - last_sofo, FRAME);
      last_sofo = vb_cnt;
    end
  endtask

  function automatic logic [7:0] fbyte(input int pos, input int bad_at);
    logic [7:0] b;
    if (pos < 6) begin
      b = pat(pos);
      if (pos == bad_at) b = ~b;
    end else begin
      b = 8'($urandom);
    end
    return b;
  endfunction

  task automatic send(input int n, input int bad_at, input int gap_pct,
                      input bit sofi0, input bit rnd_sofi);
    logic s;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct)
        cycle(1'b1, 8'($urandom), 1'b0, 1'($urandom), 1'b1);
      s = (sofi0 && g_pos == 0) || (rnd_sofi && ($urandom % 16 == 0));
      cycle(1'b1, fbyte(g_pos, bad_at), 1'b1, s, 1'b1);
      g_pos = (g_pos + 1) % FRAME;
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] d;
    logic       v;
    logic       s;
    logic [7:0] x_pdo;
    logic       x_pvldo;
    logic [8:0] x_col;
    logic [1:0] x_state;
    logic       x_oof;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [7:0] d;
    logic v, s;

    model_reset();
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 9'd0, 2'd0, 1'b1};
    tbl[1]  = '{1'b0, 8'h11, 1'b1, 1'b1, 8'h00, 1'b0, 9'd0, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 8'hF6, 1'b1, 1'b1, 8'hF6, 1'b1, 9'd0, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 8'hF6, 1'b1, 1'b0, 8'hF6, 1'b1, 9'd1, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 9'd2, 2'd0, 1'b1};
    tbl[5]  = '{1'b1, 8'hF6, 1'b1, 1'b0, 8'hF6, 1'b1, 9'd0, 2'd0, 1'b1};
    tbl[6]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 9'd0, 2'd0, 1'b1};
    tbl[7]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 9'd0, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 8'hF6, 1'b1, 1'b1, 8'hF6, 1'b1, 9'd0, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 8'hF6, 1'b1, 1'b0, 8'hF6, 1'b1, 9'd1, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 8'hF6, 1'b1, 1'b0, 8'hF6, 1'b1, 9'd2, 2'd0, 1'b1};
    tbl[11] = '{1'b1, 8'h28, 1'b1, 1'b0, 8'h28, 1'b1, 9'd3, 2'd0, 1'b1};
    tbl[12] = '{1'b1, 8'h28, 1'b0, 1'b0, 8'h28, 1'b0, 9'd3, 2'd0, 1'b1};
    tbl[13] = '{1'b1, 8'h28, 1'b1, 1'b0, 8'h28, 1'b1, 9'd4, 2'd0, 1'b1};
    tbl[14] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 9'd5, 2'd0, 1'b1};
    tbl[15] = '{1'b1, 8'hF6, 1'b1, 1'b0, 8'hF6, 1'b1, 9'd0, 2'd0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].rst_n, tbl[i].d, tbl[i].v, tbl[i].s, 1'b0);
      check($sformatf("tbl%0d_pdo", i), pdo, tbl[i].x_pdo);
      check($sformatf("tbl%0d_pvldo", i), pvldo, tbl[i].x_pvldo);
      check($sformatf("tbl%0d_col", i), col, tbl[i].x_col);
      check($sformatf("tbl%0d_row", i), row, 0);
      check($sformatf("tbl%0d_state", i), state, tbl[i].x_state);
      check($sformatf("tbl%0d_oof", i), oof, tbl[i].x_oof);
      check($sformatf("tbl%0d_lof", i), lof, 0);
      check($sformatf("tbl%0d_toh", i), toh_en, 0);
    end

    // Clean lock from a single sofi.
    g_pos = 0;
    send(7, -1, 0, 1'b1, 1'b0);
    check("lock_presync", state, 1);
    check("lock_presync_oof", oof, 1);
    send(FRAME, -1, 0, 1'b0, 1'b0);
    check("lock_sync", state, 2);
    check("lock_sync_oof", oof, 0);
    sofo_cnt = 0;
    send(2 * FRAME, -1, 0, 1'b0, 1'b0);
    check("lock_sofo_cnt", sofo_cnt, 2);

    // SYNC tolerates OOF_K-1 bad frames; OOF_K in a row drops to HUNT.
    send(FRAME - g_pos, -1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send(FRAME, 4, 0, 1'b0, 1'b0);
    send(FRAME, -1, 0, 1'b0, 1'b0);
    check("tol_state", state, 2);
    check("tol_oof", oof, 0);
    for (int k = 0; k < 3; k++) send(FRAME, 4, 0, 1'b0, 1'b0);
    send(7, 4, 0, 1'b0, 1'b0);
    check("oof_state", state, 0);
    check("oof_set", oof, 1);

    // LOF set from reset with no pattern, then cleared after relock.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < LSET * FRAME; i++) begin
      d = 8'($urandom);
      if (d == A1) d = 8'h00;
      cycle(1'b1, d, 1'b1, 1'b0, 1'b1);
    end
    check("lof_not_early", lof, 0);
    cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    check("lof_set", lof, 1);
    g_pos = 0;
    send(7, -1, 0, 1'b1, 1'b0);
    send(FRAME, -1, 0, 1'b0, 1'b0);
    check("lof_relock_state", state, 2);
    check("lof_held", lof, 1);
    send(LCLR * FRAME + 2, -1, 0, 1'b0, 1'b0);
    check("lof_clear", lof, 0);

    // Locked stream with ~50% pvld gaps and stray sofi.
    sofo_cnt = 0;
    send(2 * FRAME, -1, 50, 1'b0, 1'b1);
    check("gap_sofo_cnt", sofo_cnt, 2);
    check("gap_state", state, 2);

    // Reset at row 4, col 100 while in SYNC.
    send((4 * 270 + 100 - g_pos + FRAME) % FRAME, -1, 0, 1'b0, 1'b0);
    check("mid_pre_state", state, 2);
    cycle(1'b0, fbyte(g_pos, -1), 1'b1, 1'b0, 1'b1);
    check("mid_state", state, 0);
    check("mid_oof", oof, 1);
    check("mid_lof", lof, 0);
    check("mid_row", row, 0);
    check("mid_col", col, 0);
    check("mid_toh", toh_en, 0);
    check("mid_spe", spe_en, 0);
    check("mid_sofo", sofo, 0);
    check("mid_pvldo", pvldo, 0);
    g_pos = 0;

    // Randomized mix: mostly framed stream with corruption, gaps, stray sofi.
    for (int i = 0; i < 6000; i++) begin
      v = ($urandom % 4) != 0;
      if (v) begin
        d = ($urandom % 16 == 0) ? 8'($urandom) : fbyte(g_pos, -1);
        s = (g_pos == 0 && ($urandom % 2 == 0)) || ($urandom % 64 == 0);
        g_pos = (g_pos + 1) % FRAME;
      end else begin
        d = 8'($urandom);
        s = 1'($urandom);
      end
      cycle(($urandom % 4000) != 0, d, v, s, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_stm_frmctl.md
# rx_stm_frmctl

Byte-domain frame alignment controller for the STM-1 receive path. It consumes the byte stream and proposed frame-start marker from the serial-to-parallel stage, validates the A1/A2 framing pattern, and runs the HUNT/PRESYNC/SYNC state machine with OOF and LOF declaration. It maintains row and column counters and drives the frame-start, transport-overhead and payload enables that sequence all downstream STM-1 byte processing.

## Interface

Parameters:
- A1_VAL, 8'hF6: A1 framing byte value.
- A2_VAL, 8'h28: A2 framing byte value.
- PRESYNC_N, 2: consecutive good frames in PRESYNC required to enter SYNC.
- OOF_N, 4: consecutive bad frames in SYNC required to declare OOF.
- LOF_SET, 24: frame ticks with OOF continuously asserted before LOF is set (3 ms).
- LOF_CLR, 24: frame ticks continuously in SYNC before LOF is cleared.

Ports:
- clk19, in, 1: byte clock, 19.44 MHz.
- rst19_n, in, 1: synchronous reset, active low.
- pdi, in, 8: received byte.
- pvld, in, 1: pdi/sofi valid. All inputs are ignored when low.
- sofi, in, 1: upstream proposal that pdi is row 0, column 0.
- pdo, out, 8: registered copy of pdi.
- pvldo, out, 1: registered pvld.
- sofo, out, 1: high with the row 0, column 0 byte, only in SYNC.
- row, out, 4: current row, 0..8.
- col, out, 9: current column, 0..269.
- toh_en, out, 1: byte is transport overhead (col < 9), PRESYNC/SYNC only.
- spe_en, out, 1: byte is payload (col >= 9), PRESYNC/SYNC only.
- oof, out, 1: out-of-frame.
- lof, out, 1: loss-of-frame.
- state, out, 2: 0 = HUNT, 1 = PRESYNC, 2 = SYNC.

## Operation

- **Reset values.** After reset: state = HUNT, oof = 1, lof = 0, row = 0, col = 0. sofo, toh_en, spe_en, pvldo = 0 and pdo = 0. All internal counters = 0.
- **Position counter.** Advances only on pvld. col goes 0..269; on wrap it returns to 0 and row increments, and row wraps 8 to 0. One frame is 2430 valid bytes.
- **Pattern check.** The pattern window is row 0, cols 0..5. It requires A1, A1, A1, A2, A2, A2. A sticky mismatch flag is set on any differing byte. The verdict is taken on the col-5 byte.
- **HUNT.**
  - Counters are held at 0.
  - A valid byte with sofi=1 that equals A1_VAL starts a candidate: col becomes 1 on the next valid byte.
  - Any mismatch during cols 1..5 aborts the candidate: counters return to 0 and the block waits for the next sofi.
  - If sofi arrives during an aborting byte, it is ignored.
  - A full match at col 5 moves the state to PRESYNC.
- **PRESYNC.**
  - Counters free-run, and sofi is ignored.
  - Each frame's verdict is evaluated. A good verdict increments the good count; on reaching PRESYNC_N the state moves to SYNC.
  - Any bad verdict returns the state to HUNT and clears the counters.
- **SYNC.**
  - sofi is ignored; the controller's own counters are authoritative.
  - A bad verdict increments the bad count and a good verdict clears it.
  - When the bad count reaches OOF_N, the state moves to HUNT and oof is set.
- **oof.**
  - Set on entry to HUNT from SYNC.
  - Cleared on entry to SYNC.
  - A PRESYNC failure does not clear oof.
- **LOF timer.**
  - A free-running 12-bit counter of valid bytes, 0..2429, that ignores state. Its wrap is the frame tick.
  - While oof=1, ticks count up to LOF_SET, at which point lof is set; the count clears whenever oof=0.
  - While lof=1 and state = SYNC, ticks count up to LOF_CLR, at which point lof is cleared; the count clears on leaving SYNC.
- **Enables.** sofo, toh_en and spe_en are derived from the position of the byte being output.

## Timing

- **Latency.** All outputs are registered with 1-cycle latency. pdo, pvldo, row, col, toh_en, spe_en and sofo all describe the same byte, the one presented on the previous cycle.
- **pvld gaps.** pvld may drop for any number of cycles. During a gap, counters and state hold, and pvldo, sofo, toh_en and spe_en are 0.
- **Verdict timing.** A state change caused by a verdict is visible on the cycle after the col-5 byte's output.
- **sofo.** The first sofo pulse occurs on the row 0, col 0 byte of the frame that follows the SYNC transition.
- **Same-tick events.** If a frame tick and an oof change fall on the same byte, the oof change is applied first, then the tick is counted against the new oof value.
- **Reset.** Asserting rst19_n low mid-frame returns every register to its reset value on the next edge.

## Test plan

- **Clean lock.** Send a clean frame stream with sofi on col 0 of the first frame. Expect state 0→1 after frame 1 col 5 and 1→2 after frame 2 col 5, then oof=0. sofo pulses every 2430 valid bytes starting from frame 3.
- **HUNT abort.** Assert sofi on a byte F6, followed by F6, 00. Expect an abort (col back to 0, state HUNT). A later correct sofi still locks.
- **SYNC tolerance.** In SYNC, corrupt A2 in 3 consecutive frames and then send 1 good frame. Expect state to stay 2 and oof=0. Then corrupt 4 consecutive frames: expect state 0 and oof=1 after the 4th frame's col 5.
- **LOF set and clear.** Hold a stream with no valid pattern from reset. Expect lof=1 after 24 × 2430 valid bytes. Then restore framing: lof drops 24 frame ticks after state reaches 2.
- **pvld gaps.** Insert a random pvld duty cycle of about 50% into a locked stream. Expect row/col and sofo spacing unchanged in valid-byte terms, with pvldo mirroring pvld one cycle later.
- **Mid-frame reset.** Assert rst19_n=0 for 1 cycle at row 4, col 100 in SYNC. Expect state 0, oof=1, lof=0, row=col=0 and all enables 0 on the following cycle.
